// File: rtl/fifo_v4_thresh.sv
//============================================================================
// Module   : fifo_v4_thresh
// Brief    : Synchronous FIFO with full-range usage count, programmable
//            almost-full/almost-empty flags and optional fall-through.
//            Optional sticky overflow/underflow flags: FIFO_V4_THRESH_ERR_EN
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module fifo_v4_thresh #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH:0]   usage_o,
    input  logic [ADDR_DEPTH:0]   af_thresh_i,
    input  logic [ADDR_DEPTH:0]   ae_thresh_i,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i,
    input  logic                  err_clr_i,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_DEPTH:0]   c_depth_cnt = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH:0]   c_cnt_one   = (ADDR_DEPTH+1)'(1);
    localparam logic [ADDR_DEPTH-1:0] c_last_ptr  = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH-1:0] c_ptr_one   = ADDR_DEPTH'(1);

    logic [ADDR_DEPTH-1:0] r_rd_ptr, r_wr_ptr;
    logic [ADDR_DEPTH-1:0] w_rd_ptr_nxt, w_wr_ptr_nxt;
    logic [ADDR_DEPTH:0]   r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_cnt_zero;
    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + c_ptr_one;
    endfunction

    assign w_cnt_zero = (r_cnt == '0);
    assign w_full     = (r_cnt == c_depth_cnt);
    assign w_empty    = FALL_THROUGH ? (w_cnt_zero && !push_i) : w_cnt_zero;

    // Fall-through push+pop on an empty FIFO hands data_i straight to the
    // consumer without touching storage, pointers or count.
    assign w_bypass = FALL_THROUGH && w_cnt_zero && push_i && pop_i;
    assign w_push   = push_i && !w_full  && !w_bypass;
    assign w_pop    = pop_i  && !w_empty && !w_bypass;

    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_cnt_nxt    = r_cnt;
        if (flush_i) begin
            w_rd_ptr_nxt = '0;
            w_wr_ptr_nxt = '0;
            w_cnt_nxt    = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
            if (w_pop)  w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   w_cnt_nxt = r_cnt + c_cnt_one;
                2'b01:   w_cnt_nxt = r_cnt - c_cnt_one;
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign usage_o        = r_cnt;
    assign almost_full_o  = (r_cnt >= af_thresh_i);
    assign almost_empty_o = (r_cnt <= ae_thresh_i);
    assign data_o         = (FALL_THROUGH && w_cnt_zero) ? data_i : r_mem[r_rd_ptr];

`ifdef FIFO_V4_THRESH_ERR_EN
    logic r_overflow, r_underflow;

    // A new error event outranks a simultaneous clear request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push_i && w_full)      r_overflow <= 1'b1;
            else if (err_clr_i)        r_overflow <= 1'b0;
            if (pop_i && w_empty)      r_underflow <= 1'b1;
            else if (err_clr_i)        r_underflow <= 1'b0;
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

    logic w_unused;
    assign w_unused = testmode_i;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;

    logic w_unused;
    assign w_unused = ^{testmode_i, err_clr_i};
`endif

endmodule

`default_nettype wire
